code_converter_seq: RTL and testbench
=====================================

# code_converter_seq

Parametrised, multi-cycle binary/BCD code converter for the ALU datapath. It accepts one operand per start pulse and converts it in one of two modes: binary-to-BCD by iterative shift-add-3 (double dabble), or BCD-to-binary by iterative multiply-by-10 accumulate. It returns the result with a one-cycle `done` pulse, and flags invalid or overflowing BCD input. It replaces the single-width converter with a width-generic, handshaked, registered block.

## Interface

Parameters:
- `BIN_W`, default 8: binary operand/result width.
- `DIGITS`, default 3: number of BCD digits. Legal only if 10^DIGITS > 2^BIN_W − 1 and BIN_W ≤ 4*DIGITS.

Ports:
- `clk_in`, input, 1: single clock; all state changes on the rising edge.
- `rst_n_in`, input, 1: asynchronous, active-low reset.
- `en_in`, input, 1: start request; sampled only in IDLE.
- `mode_in`, input, 1: 0 = binary→BCD, 1 = BCD→binary; captured at start.
- `a_in`, input, 4*DIGITS: operand, captured at start. In mode 0 only bits [BIN_W-1:0] are used.
- `y_out`, output, 4*DIGITS: result register. In mode 1 the result is zero-extended from BIN_W.
- `done`, output, 1: one-cycle pulse when `y_out`/`err_out` update.
- `busy_out`, output, 1: high while a conversion is in progress.
- `err_out`, output, 1: error status of the last conversion; updated with `done`.

## Operation

- States: IDLE, CONV.
- **IDLE → CONV** on a clock edge with `en_in`=1.
  - Capture `a_in` and `mode_in`.
  - Clear the iteration counter and working registers.
  - Set `busy_out`=1.
- **Mode 0 (binary→BCD)** runs BIN_W iterations, MSB first.
  - Each iteration: every 4-bit BCD digit ≥ 5 gets +3, then the {BCD, binary} register shifts left by 1.
  - No error is possible in this mode; `err_out`=0.
- **Mode 1 (BCD→binary)** runs DIGITS iterations, most significant digit first.
  - Each iteration: acc ← acc*10 + digit, with acc 4*DIGITS bits wide and *10 computed as (acc<<3)+(acc<<1).
  - Any digit > 9 sets a sticky invalid flag.
  - At the end, if the invalid flag is set or acc ≥ 2^BIN_W: `err_out`=1 and `y_out`=0.
  - Otherwise: `err_out`=0 and `y_out`=acc.
- **CONV → IDLE** on the edge that completes the final iteration.
  - That edge writes `y_out` and `err_out`, sets `done`=1 and clears `busy_out`.
  - `done` clears on the next edge unless a new conversion completes there.
- `y_out` and `err_out` hold their values until the next completion; they are never updated mid-conversion.
- `en_in` while in CONV is ignored, not queued. `a_in` and `mode_in` changes during CONV have no effect.
- Reset, asynchronous, at any time including mid-conversion:
  - state = IDLE, counter = 0;
  - `y_out`=0, `done`=0, `busy_out`=0, `err_out`=0;
  - the in-progress conversion is discarded and produces no `done`.

## Timing

- Let edge E0 be the edge that accepts `en_in`.
- Mode 0: `done` and the new `y_out` are visible in the cycle after edge E_BIN_W. Latency is BIN_W clocks (8 at default).
- Mode 1: latency is DIGITS clocks (3 at default).
- `busy_out` is high from after E0 until the completion edge. It is never high in the same cycle as `done`.
- Back-to-back: `en_in`=1 during the `done` cycle, when the state is already IDLE, is accepted.
  - Mode 0 sustains one result every BIN_W+1 clocks.
  - Mode 1 sustains one result every DIGITS+1 clocks.
- Reset deassertion is synchronised by the environment. The first edge after deassertion may accept `en_in`.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan

- **Mode 0 sweep.** Apply `a_in` = 8'b0001_0010, 8'b0010_0010, 8'b0100_0010, 8'b1000_0010.
  - Required `y_out`: 12'h018, 12'h034, 12'h066, 12'h130.
  - `done` pulses exactly 8 clocks after each accept; `err_out`=0.
- **Mode 0 extremes.** `a_in`=0 → `y_out`=12'h000. `a_in`=255 → `y_out`=12'h255.
  - Also check every value 0–255 against a reference model.
- **Mode 1 valid.** `a_in`=12'h255 → `y_out`=12'h0FF, `err_out`=0, `done` 3 clocks after accept. `a_in`=12'h000 → `y_out`=0.
- **Mode 1 errors.**
  - `a_in`=12'h256 → `err_out`=1, `y_out`=0 (overflow).
  - `a_in`=12'h1A3 → `err_out`=1, `y_out`=0 (invalid digit).
  - A following conversion of 12'h042 → `err_out`=0, `y_out`=12'h02A.
- **Handshake.**
  - `en_in` pulsed at cycle 3 of a mode-0 conversion: ignored, and exactly one `done`.
  - `en_in` held high through the `done` cycle: a second conversion starts immediately, and `busy_out` is low only during the `done` cycle.
- **Reset mid-operation.** Assert `rst_n_in` low 4 clocks into a mode-0 conversion of 200.
  - All outputs are 0 immediately (asynchronous), and no `done` pulse follows.
  - After release, a conversion of 99 gives 12'h099.

Source files
------------

// File: rtl/code_converter_seq.sv
// Multi-cycle binary<->BCD converter: double dabble for binary->BCD,
// multiply-by-10 accumulate for BCD->binary, with done pulse and BCD error flag.
//
// state | meaning
// IDLE  | waiting for en_in; operand and mode captured on accept
// CONV  | one iteration per clock; the final iteration writes y_out/err_out
module code_converter_seq #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic                en_in,
    input  logic                mode_in,
    input  logic [4*DIGITS-1:0] a_in,
    output logic [4*DIGITS-1:0] y_out,
    output logic                done,
    output logic                busy_out,
    output logic                err_out
);

    localparam int AW   = 4 * DIGITS;
    localparam int MAXI = (BIN_W > DIGITS) ? BIN_W : DIGITS;
    localparam int CW   = $clog2(MAXI + 1);
    localparam logic [AW:0] LIMIT = {{AW{1'b0}}, 1'b1} << BIN_W;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic            mode_q;
    logic [CW-1:0]   cnt_q;
    logic [AW-1:0]   bcd_q;
    logic [BIN_W-1:0] bin_q;
    logic [AW-1:0]   src_q;
    logic [AW-1:0]   acc_q;
    logic            inv_q;

    logic            start, last, finish, ovf, inv_d;
    logic [3:0]      digit;
    logic [AW-1:0]   bcd_adj, bcd_d, acc_d;
    logic [BIN_W-1:0] bin_d;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state_q <= IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        finish  = 1'b0;
        last    = mode_q ? (cnt_q == CW'(DIGITS - 1)) : (cnt_q == CW'(BIN_W - 1));
        case (state_q)
            IDLE: if (en_in) begin
                start   = 1'b1;
                state_d = CONV;
            end
            CONV: if (last) begin
                finish  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: add-3 adjust then shift in the next binary MSB.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        bcd_d = (bcd_adj << 1) | AW'(bin_q[BIN_W-1]);
        bin_d = bin_q << 1;
        digit = src_q[AW-1 -: 4];
        acc_d = (acc_q << 3) + (acc_q << 1) + AW'(digit);
        inv_d = inv_q | (digit > 4'd9);
        ovf   = ({1'b0, acc_d} >= LIMIT);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            mode_q  <= 1'b0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            bin_q   <= '0;
            src_q   <= '0;
            acc_q   <= '0;
            inv_q   <= 1'b0;
            y_out   <= '0;
            err_out <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= finish;
            if (start) begin
                mode_q <= mode_in;
                cnt_q  <= '0;
                bcd_q  <= '0;
                bin_q  <= a_in[BIN_W-1:0];
                src_q  <= a_in;
                acc_q  <= '0;
                inv_q  <= 1'b0;
            end else if (state_q == CONV) begin
                cnt_q <= cnt_q + CW'(1);
                if (mode_q) begin
                    acc_q <= acc_d;
                    src_q <= src_q << 4;
                    inv_q <= inv_d;
                end else begin
                    bcd_q <= bcd_d;
                    bin_q <= bin_d;
                end
            end
            if (finish) begin
                if (!mode_q) begin
                    y_out   <= bcd_d;
                    err_out <= 1'b0;
                end else if (inv_d || ovf) begin
                    y_out   <= '0;
                    err_out <= 1'b1;
                end else begin
                    y_out   <= acc_d;
                    err_out <= 1'b0;
                end
            end
        end
    end

    assign busy_out = (state_q == CONV);

endmodule

// File: tb/tb_code_converter_seq.sv
// Directed bench for code_converter_seq at default parameters (BIN_W=8, DIGITS=3).
module tb_code_converter_seq;

    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b1;
    logic        en_in = 1'b0;
    logic        mode_in = 1'b0;
    logic [11:0] a_in = '0;
    logic [11:0] y_out;
    logic        done, busy_out, err_out;

    int checks = 0;
    int failures = 0;

    code_converter_seq #(.BIN_W(8), .DIGITS(3)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .en_in(en_in), .mode_in(mode_in),
        .a_in(a_in), .y_out(y_out), .done(done), .busy_out(busy_out), .err_out(err_out)
    );

    always #5 clk_in = ~clk_in;

    // Stimulus only: runs one conversion, returns result and latency (-1 on timeout).
    task automatic convert(input logic m, input logic [11:0] a,
                           output logic [11:0] y, output logic e, output int lat);
        lat = -1;
        @(negedge clk_in);
        en_in = 1'b1; mode_in = m; a_in = a;
        @(negedge clk_in);
        en_in = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk_in); #1;
            if (done) begin
                lat = k;
                break;
            end
        end
        y = y_out;
        e = err_out;
    endtask

    function automatic logic [11:0] bcd_of(input int v);
        return 12'(((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10));
    endfunction

    task automatic test_reset();
        #2 rst_n_in = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        checks++; if (y_out !== 12'h000) begin failures++; $display("FAIL reset_y got=%h exp=000", y_out); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (busy_out !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_out); end
        checks++; if (err_out !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err_out); end
        @(negedge clk_in);
        rst_n_in = 1'b1;
    endtask

    task automatic test_mode0_sweep();
        logic [11:0] vin [4] = '{12'h012, 12'h022, 12'h042, 12'h082};
        logic [11:0] vexp[4] = '{12'h018, 12'h034, 12'h066, 12'h130};
        logic [11:0] y; logic e; int lat;
        for (int i = 0; i < 4; i++) begin
            convert(1'b0, vin[i], y, e, lat);
            checks++; if (y !== vexp[i]) begin failures++; $display("FAIL m0_sweep_y in=%h got=%h exp=%h", vin[i], y, vexp[i]); end
            checks++; if (lat != 8) begin failures++; $display("FAIL m0_sweep_lat in=%h got=%0d exp=8", vin[i], lat); end
            checks++; if (e !== 1'b0) begin failures++; $display("FAIL m0_sweep_err in=%h got=%b exp=0", vin[i], e); end
        end
    endtask

    task automatic test_mode0_extremes();
        logic [11:0] y; logic e; int lat;
        convert(1'b0, 12'd0, y, e, lat);
        checks++; if (y !== 12'h000) begin failures++; $display("FAIL m0_zero got=%h exp=000", y); end
        convert(1'b0, 12'd255, y, e, lat);
        checks++; if (y !== 12'h255) begin failures++; $display("FAIL m0_max got=%h exp=255", y); end
        // Upper operand bits are junk in mode 0 and must be ignored.
        for (int v = 0; v < 256; v++) begin
            convert(1'b0, {4'hA, 8'(v)}, y, e, lat);
            checks++;
            if (y !== bcd_of(v) || e !== 1'b0 || lat != 8) begin
                failures++;
                $display("FAIL m0_all v=%0d got=%h/%b/%0d exp=%h/0/8", v, y, e, lat, bcd_of(v));
            end
        end
    endtask

    task automatic test_mode1_valid();
        logic [11:0] y; logic e; int lat;
        convert(1'b1, 12'h255, y, e, lat);
        checks++; if (y !== 12'h0FF) begin failures++; $display("FAIL m1_255_y got=%h exp=0ff", y); end
        checks++; if (e !== 1'b0) begin failures++; $display("FAIL m1_255_err got=%b exp=0", e); end
        checks++; if (lat != 3) begin failures++; $display("FAIL m1_255_lat got=%0d exp=3", lat); end
        convert(1'b1, 12'h000, y, e, lat);
        checks++; if (y !== 12'h000 || e !== 1'b0) begin failures++; $display("FAIL m1_zero got=%h/%b exp=000/0", y, e); end
    endtask

    task automatic test_mode1_errors();
        logic [11:0] y; logic e; int lat;
        convert(1'b1, 12'h256, y, e, lat);
        checks++; if (y !== 12'h000 || e !== 1'b1) begin failures++; $display("FAIL m1_ovf got=%h/%b exp=000/1", y, e); end
        convert(1'b1, 12'h1A3, y, e, lat);
        checks++; if (y !== 12'h000 || e !== 1'b1) begin failures++; $display("FAIL m1_inv got=%h/%b exp=000/1", y, e); end
        convert(1'b1, 12'h042, y, e, lat);
        checks++; if (y !== 12'h02A || e !== 1'b0) begin failures++; $display("FAIL m1_recover got=%h/%b exp=02a/0", y, e); end
    endtask

    task automatic test_handshake_ignore();
        int ndone = 0; int lat = -1;
        @(negedge clk_in);
        en_in = 1'b1; mode_in = 1'b0; a_in = 12'h012;
        @(negedge clk_in);
        en_in = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk_in); #1;
            if (done) begin ndone++; lat = k; end
            @(negedge clk_in);
            en_in = (k == 3);
            if (k == 3) begin mode_in = 1'b1; a_in = 12'h099; end
        end
        en_in = 1'b0;
        checks++; if (ndone != 1) begin failures++; $display("FAIL hs_ignore_count got=%0d exp=1", ndone); end
        checks++; if (lat != 8) begin failures++; $display("FAIL hs_ignore_lat got=%0d exp=8", lat); end
        checks++; if (y_out !== 12'h018) begin failures++; $display("FAIL hs_ignore_y got=%h exp=018", y_out); end
    endtask

    task automatic test_back_to_back();
        logic exp_done, exp_busy;
        @(negedge clk_in);
        en_in = 1'b1; mode_in = 1'b0; a_in = 12'd130;
        @(negedge clk_in);
        a_in = 12'd77;
        for (int k = 1; k <= 18; k++) begin
            @(posedge clk_in); #1;
            exp_done = (k == 8) || (k == 17);
            exp_busy = (k < 17) && (k != 8);
            checks++;
            if (done !== exp_done || busy_out !== exp_busy) begin
                failures++;
                $display("FAIL b2b_cycle k=%0d got=%b/%b exp=%b/%b", k, done, busy_out, exp_done, exp_busy);
            end
            if (k == 8) begin
                checks++; if (y_out !== 12'h130) begin failures++; $display("FAIL b2b_first got=%h exp=130", y_out); end
            end
            if (k == 17) begin
                checks++; if (y_out !== 12'h077) begin failures++; $display("FAIL b2b_second got=%h exp=077", y_out); end
            end
            @(negedge clk_in);
            if (k == 9) en_in = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        int ndone = 0;
        logic [11:0] y; logic e; int lat;
        @(negedge clk_in);
        en_in = 1'b1; mode_in = 1'b0; a_in = 12'd200;
        @(negedge clk_in);
        en_in = 1'b0;
        repeat (4) @(posedge clk_in);
        #2 rst_n_in = 1'b0;
        #1;
        checks++;
        if (y_out !== 12'h000 || done !== 1'b0 || busy_out !== 1'b0 || err_out !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_outputs got=%h/%b/%b/%b exp=000/0/0/0", y_out, done, busy_out, err_out);
        end
        @(negedge clk_in);
        rst_n_in = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk_in); #1;
            if (done) ndone++;
        end
        checks++; if (ndone != 0) begin failures++; $display("FAIL rst_mid_nodone got=%0d exp=0", ndone); end
        convert(1'b0, 12'd99, y, e, lat);
        checks++; if (y !== 12'h099 || lat != 8) begin failures++; $display("FAIL rst_mid_after got=%h/%0d exp=099/8", y, lat); end
    endtask

    initial begin
        test_reset();
        test_mode0_sweep();
        test_mode0_extremes();
        test_mode1_valid();
        test_mode1_errors();
        test_handshake_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
